// File: rtl/shootemup_pkg.sv
// Playfield bounds, bullet geometry/colour and the bullet slot record shared by
// the shoot-'em-up sprite modules.
package shootemup_pkg;

   localparam logic [9:0] BOUND_LEFT  = 10'd144;
   localparam logic [9:0] BOUND_RIGHT = 10'd784;
   localparam logic [9:0] BOUND_UP    = 10'd31;
   localparam logic [9:0] BOUND_DOWN  = 10'd511;

   localparam logic [9:0] BULLET_W   = 10'd2;
   localparam logic [9:0] BULLET_H   = 10'd6;
   localparam logic [7:0] BULLET_RGB = 8'hFC;

   typedef struct packed {
      logic       live;
      logic [9:0] bx;
      logic [9:0] by;
   } slot_t;

endpackage

// File: rtl/bullet_slot.sv
// One player-bullet slot: position registers, upward motion step, pixel box
// compare and retire on enemy overlap or on leaving the top of the playfield.
module bullet_slot
   import shootemup_pkg::*;
#(
   parameter int STEP = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       tick,
   input  logic       spawn,
   input  logic [9:0] spawn_bx,
   input  logic [9:0] spawn_by,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic       e_on,
   output logic       slot_on,
   output logic       live
);

   slot_t slot_q, slot_d;
   logic  in_x, in_y, at_top;

   // 11-bit compares so a box touching the 10-bit limit cannot wrap.
   assign in_x   = ({1'b0, x} >= {1'b0, slot_q.bx}) &&
                   ({1'b0, x} <  ({1'b0, slot_q.bx} + {1'b0, BULLET_W}));
   assign in_y   = ({1'b0, y} >= {1'b0, slot_q.by}) &&
                   ({1'b0, y} <  ({1'b0, slot_q.by} + {1'b0, BULLET_H}));
   assign at_top = {1'b0, slot_q.by} < ({1'b0, BOUND_UP} + 11'(STEP));

   assign slot_on = slot_q.live && in_x && in_y;
   assign live    = slot_q.live;

   always_comb begin
      slot_d = slot_q;
      if (clear) begin
         slot_d.live = 1'b0;
      end else if (slot_q.live) begin
         // A hit outranks a same-cycle tick: the slot retires where it is.
         if (slot_on && e_on) begin
            slot_d.live = 1'b0;
         end else if (tick) begin
            if (at_top) slot_d.live = 1'b0;
            else        slot_d.by   = slot_q.by - 10'(STEP);
         end
      end else if (spawn) begin
         slot_d = '{live: 1'b1, bx: spawn_bx, by: spawn_by};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) slot_q <= '0;
      else        slot_q <= slot_d;
   end

endmodule

// File: rtl/player_bullet.sv
// Player projectile pool: fire edge detect, lowest-free slot allocation, motion
// tick and pixel OR. Define BULLET_AUTOFIRE_EN to add repeat fire while held.
module player_bullet
   import shootemup_pkg::*;
#(
   parameter int          NUM_BULLETS     = 4,
   parameter logic [23:0] BULLET_SPEED    = 24'd250000,
   parameter int          STEP            = 2,
   parameter logic [23:0] AUTOFIRE_PERIOD = 24'd5000000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pause,
   input  logic                   game_start_on,
   input  logic                   game_over_on,
   input  logic                   fire,
   input  logic [9:0]             player_x,
   input  logic [9:0]             player_y,
   input  logic [9:0]             x,
   input  logic [9:0]             y,
   input  logic                   e_on,
   output logic                   b_on,
   output logic [7:0]             rgb,
   output logic                   fire_ack,
   output logic [NUM_BULLETS-1:0] active_mask
);

   logic                   clear;
   logic                   fire_q, fire_prev_q;
   logic                   fire_ack_q;
   logic                   fire_req, spawn_ok;
   logic [23:0]            tick_cnt_q, tick_cnt_d;
   logic                   tick;
   logic [NUM_BULLETS-1:0] live, free, spawn_sel, slot_on;
   logic [9:0]             spawn_bx, spawn_by;

   assign clear = game_start_on | game_over_on;

`ifdef BULLET_AUTOFIRE_EN
   logic [23:0] auto_cnt_q, auto_cnt_d;
   logic        auto_req;

   assign auto_req = fire_q && !pause && (auto_cnt_q == AUTOFIRE_PERIOD - 24'd1);
   assign fire_req = (fire_q && !fire_prev_q) || auto_req;

   // Restarts on every spawn attempt so repeats are spaced from the last try.
   always_comb begin
      auto_cnt_d = auto_cnt_q + 24'd1;
      if (!fire_q)       auto_cnt_d = '0;
      else if (pause)    auto_cnt_d = auto_cnt_q;
      else if (fire_req) auto_cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) auto_cnt_q <= '0;
      else        auto_cnt_q <= auto_cnt_d;
   end
`else
   assign fire_req = fire_q && !fire_prev_q;
`endif

   // Free slots come from pre-edge live bits, so a retiring slot is not reused.
   assign free      = ~live;
   assign spawn_ok  = fire_req && !pause && !clear && (|free);
   assign spawn_sel = spawn_ok ? (free & (~free + NUM_BULLETS'(1))) : '0;
   assign spawn_bx  = player_x + 10'd7;
   assign spawn_by  = player_y - BULLET_H;

   assign tick = !pause && !clear && (tick_cnt_q == BULLET_SPEED - 24'd1);

   always_comb begin
      tick_cnt_d = tick_cnt_q + 24'd1;
      if (clear)      tick_cnt_d = '0;
      else if (pause) tick_cnt_d = tick_cnt_q;
      else if (tick)  tick_cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fire_q      <= 1'b0;
         fire_prev_q <= 1'b0;
         fire_ack_q  <= 1'b0;
         tick_cnt_q  <= '0;
      end else begin
         fire_q      <= fire;
         fire_prev_q <= fire_q;
         fire_ack_q  <= spawn_ok;
         tick_cnt_q  <= tick_cnt_d;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_BULLETS; gi++) begin : g_slot
         bullet_slot #(.STEP(STEP)) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (clear),
            .tick     (tick),
            .spawn    (spawn_sel[gi]),
            .spawn_bx (spawn_bx),
            .spawn_by (spawn_by),
            .x        (x),
            .y        (y),
            .e_on     (e_on),
            .slot_on  (slot_on[gi]),
            .live     (live[gi])
         );
      end
   endgenerate

   assign b_on        = |slot_on;
   assign rgb         = BULLET_RGB;
   assign fire_ack    = fire_ack_q;
   assign active_mask = live;

endmodule

// File: tb/tb_player_bullet.sv
// Bench for player_bullet: fire_ack scoreboard keyed by cycle, a pixel-scan
// vector table and hand-timed sequences for motion, hit, clear and reset.
`timescale 1ns/1ps
module tb_player_bullet;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pause = 1'b0;
   logic       game_start_on = 1'b0;
   logic       game_over_on = 1'b0;
   logic       fire = 1'b0;
   logic       e_on = 1'b0;
   logic [9:0] player_x = '0, player_y = '0, x = '0, y = '0;
   logic       b_on, fire_ack;
   logic [7:0] rgb;
   logic [3:0] active_mask;

   int n_checks = 0;
   int n_errors = 0;
   int cyc_n = 0;

   typedef struct { int cyc; logic ack; } sb_t;
   sb_t sb_q[$];
   logic sb_hit;

   typedef struct { logic [9:0] px; logic [9:0] py; logic exp; } pix_t;
   pix_t scan_tbl[10];

   logic [3:0] exp_mask = '0;
   int c0;

   player_bullet #(
      .NUM_BULLETS     (4),
      .BULLET_SPEED    (24'd4),
      .STEP            (2),
      .AUTOFIRE_PERIOD (24'd5000000)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pause         (pause),
      .game_start_on (game_start_on),
      .game_over_on  (game_over_on),
      .fire          (fire),
      .player_x      (player_x),
      .player_y      (player_y),
      .x             (x),
      .y             (y),
      .e_on          (e_on),
      .b_on          (b_on),
      .rgb           (rgb),
      .fire_ack      (fire_ack),
      .active_mask   (active_mask)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
      end else begin
         $display("ok   %s: %0h (cycle %0d)", name, act, cyc_n);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc_n < t) cyc();
   endtask

   task automatic pix(input logic [9:0] px, input logic [9:0] py, input logic e, input string name);
      x = px;
      y = py;
      #1;
      check($sformatf("%s(%0d,%0d)", name, px, py), 32'(b_on), 32'(e));
   endtask

   // Raise fire now; the ack (or its absence) is due two edges later.
   task automatic fire_edge(input logic allowed);
      sb_t e;
      fire  = 1'b1;
      e.cyc = cyc_n + 2;
      e.ack = allowed && (exp_mask != 4'hF);
      if (e.ack) begin
         for (int i = 0; i < 4; i++) begin
            if (!exp_mask[i]) begin
               exp_mask[i] = 1'b1;
               break;
            end
         end
      end
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         sb_hit = 1'b0;
         while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_n) begin
            sb_hit = 1'b1;
            check($sformatf("fire_ack@%0d", sb_q[0].cyc), 32'(fire_ack), 32'(sb_q[0].ack));
            void'(sb_q.pop_front());
         end
         if (!sb_hit && fire_ack) begin
            n_checks++;
            n_errors++;
            $display("FAIL fire_ack_unexpected: got 1, expected 0 (cycle %0d)", cyc_n);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      scan_tbl = '{
         '{10'd306, 10'd394, 1'b0}, '{10'd307, 10'd394, 1'b1},
         '{10'd308, 10'd394, 1'b1}, '{10'd309, 10'd394, 1'b0},
         '{10'd307, 10'd393, 1'b0}, '{10'd307, 10'd399, 1'b1},
         '{10'd308, 10'd399, 1'b1}, '{10'd307, 10'd400, 1'b0},
         '{10'd308, 10'd396, 1'b1}, '{10'd0,   10'd0,   1'b0}
      };

      // Reset with fire held and the title screen up.
      rst_n = 1'b0; fire = 1'b1; game_start_on = 1'b1;
      player_x = 10'd300; player_y = 10'd400;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mask", 32'(active_mask), 32'h0);
      check("rst_b_on", 32'(b_on), 32'h0);
      check("rst_fire_ack", 32'(fire_ack), 32'h0);
      check("rst_rgb", 32'(rgb), 32'hFC);
      rst_n = 1'b1;
      cyc(); cyc();
      check("title_mask", 32'(active_mask), 32'h0);
      check("title_fire_ack", 32'(fire_ack), 32'h0);
      fire = 1'b0; game_start_on = 1'b0;
      cyc(); cyc();

      // Single shot, frozen by pause, then scanned.
      fire_edge(1'b1);
      cyc(); fire = 1'b0; cyc();
      pause = 1'b1;
      check("spawn_mask", 32'(active_mask), 32'(exp_mask));
      for (int i = 0; i < 10; i++) pix(scan_tbl[i].px, scan_tbl[i].py, scan_tbl[i].exp, "scan");

      // Pause holds position for 10 ticks and blocks a fire edge.
      c0 = cyc_n;
      fire_edge(1'b0);
      cyc(); cyc(); fire = 1'b0;
      wait_until(c0 + 40);
      check("pause_mask", 32'(active_mask), 32'(exp_mask));
      pix(10'd307, 10'd394, 1'b1, "pause_top");
      pix(10'd307, 10'd393, 1'b0, "pause_above");

      // Top-boundary retire with the tick counter aligned by a clear.
      pause = 1'b0; game_over_on = 1'b1;
      cyc();
      c0 = cyc_n;
      exp_mask = '0;
      check("clear_single", 32'(active_mask), 32'h0);
      game_over_on = 1'b0; player_y = 10'd40;
      fire_edge(1'b1);
      cyc(); fire = 1'b0; cyc();
      check("bound_spawn_mask", 32'(active_mask), 32'h1);
      pix(10'd307, 10'd34, 1'b1, "by34");
      pix(10'd307, 10'd33, 1'b0, "by34_above");
      wait_until(c0 + 4);
      pix(10'd307, 10'd32, 1'b1, "by32");
      pix(10'd307, 10'd38, 1'b0, "by32_below");
      wait_until(c0 + 7);
      check("bound_live_before", 32'(active_mask), 32'h1);
      wait_until(c0 + 8);
      check("bound_exit", 32'(active_mask), 32'h0);
      exp_mask = '0;

      // Five fire edges into four slots, each slot at its own column.
      game_over_on = 1'b1;
      cyc();
      c0 = cyc_n;
      game_over_on = 1'b0; player_y = 10'd400;
      for (int i = 0; i < 5; i++) begin
         player_x = 10'(100 + 20 * i);
         fire_edge(1'b1);
         cyc(); fire = 1'b0; cyc();
      end
      check("pool_full", 32'(active_mask), 32'hF);

      // Hit on slot 1 in the same cycle as a tick.
      wait_until(c0 + 11);
      x = 10'd127; y = 10'd392; e_on = 1'b1;
      #1;
      check("hit_coincide", 32'(b_on), 32'h1);
      cyc();
      e_on = 1'b0;
      exp_mask[1] = 1'b0;
      check("hit_mask", 32'(active_mask), 32'(exp_mask));
      pix(10'd127, 10'd392, 1'b0, "hit_gone");
      pix(10'd127, 10'd390, 1'b0, "hit_not_moved");
      pix(10'd107, 10'd388, 1'b1, "slot0_moved");
      pix(10'd107, 10'd387, 1'b0, "slot0_above");
      pix(10'd147, 10'd390, 1'b1, "slot2_moved");
      pix(10'd167, 10'd392, 1'b1, "slot3_moved");

      // Game over wipes the three survivors.
      game_over_on = 1'b1;
      cyc();
      check("gameover_clear", 32'(active_mask), 32'h0);
      pix(10'd107, 10'd388, 1'b0, "gameover_pix");
      game_over_on = 1'b0;
      exp_mask = '0;
      cyc();

      // Asynchronous reset mid-flight.
      player_x = 10'd300; player_y = 10'd400;
      fire_edge(1'b1);
      cyc(); fire = 1'b0; cyc();
      check("flight_mask", 32'(active_mask), 32'h1);
      #5;
      rst_n = 1'b0;
      #1;
      check("async_reset_mask", 32'(active_mask), 32'h0);
      check("async_reset_ack", 32'(fire_ack), 32'h0);
      cyc();
      rst_n = 1'b1;
      exp_mask = '0;
      cyc();
      check("post_reset_mask", 32'(active_mask), 32'h0);
      check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
